// File: rtl/periph_tx_responder_pkg.sv
// Shared encodings for the memory-mapped UART transmit responder.
package periph_tx_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  localparam int STAT_BUSY_BIT  = 0;
  localparam int STAT_FULL_BIT  = 1;
  localparam int STAT_EMPTY_BIT = 2;
  localparam int STAT_OVF_BIT   = 3;
  localparam int STAT_CNT_LSB   = 4;

  function automatic logic [15:0] pack_status(input logic [3:0] cnt, input logic ovf,
                                               input logic empty, input logic full,
                                               input logic busy);
    logic [15:0] s;
    s = 16'h0000;
    s[STAT_CNT_LSB +: 4] = cnt;
    s[STAT_OVF_BIT]      = ovf;
    s[STAT_EMPTY_BIT]    = empty;
    s[STAT_FULL_BIT]     = full;
    s[STAT_BUSY_BIT]     = busy;
    return s;
  endfunction

endpackage

// File: rtl/periph_tx_responder_if.sv
// CPU data-memory port as seen from the Mem stage.
interface periph_tx_responder_if;
  logic [15:0] dataAddr;
  logic [15:0] inData;
  logic        memWE;
  logic [15:0] rdData;

  modport master (output dataAddr, output inData, output memWE, input rdData);
  modport slave  (input dataAddr, input inData, input memWE, output rdData);
endinterface

// File: rtl/periph_word_fifo.sv
// Circular 16-bit word FIFO; push while full is only taken when a pop frees the slot.
module periph_word_fifo #(
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_push,
  input  logic                  i_pop,
  input  logic [15:0]           i_din,
  output logic [15:0]           o_dout,
  output logic                  o_full,
  output logic                  o_empty,
  output logic [DEPTH_LOG2:0]   o_count
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2+1)'(DEPTH);

  logic [15:0]           r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wptr, r_rptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic                  w_push, w_pop;

  assign o_full  = (r_count == FULL_CNT);
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_dout  = r_mem[r_rptr];
  assign w_pop   = i_pop & ~o_empty;
  assign w_push  = i_push & (~o_full | w_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: pointers define validity.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_din;
  end

endmodule

// File: rtl/periph_tx_responder.sv
// Store-to-UART responder: address decode, status/overflow, and 8N1 word serializer.
module periph_tx_responder
  import periph_tx_responder_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR    = 16'hFF00,
  parameter int          CLKS_PER_BIT = 434,
  parameter int          DEPTH_LOG2   = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  periph_tx_responder_if.slave  bus,
  output logic                  txd,
  output logic                  irq
);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_TC   = BW'(CLKS_PER_BIT - 1);
  localparam logic [15:0]   STAT_ADDR = BASE_ADDR + 16'd1;

  tx_state_e           r_state, w_state_nxt;
  logic [BW-1:0]       r_baud, w_baud_nxt;
  logic [2:0]          r_bit, w_bit_nxt;
  logic                r_byte_sel, w_sel_nxt;
  logic [15:0]         r_hold, w_hold_nxt;
  logic                r_txd, w_txd_nxt;
  logic                r_ovf;
  logic [15:0]         r_rd;
  logic [7:0]          w_byte_nxt;
  logic                w_tc, w_pop, w_busy;
  logic                w_sel_data, w_sel_stat, w_wr_data, w_push, w_drop;
  logic [15:0]         w_dout, w_status;
  logic                w_full, w_empty;
  logic [DEPTH_LOG2:0] w_count;

  assign w_sel_data = (bus.dataAddr == BASE_ADDR);
  assign w_sel_stat = (bus.dataAddr == STAT_ADDR);
  assign w_wr_data  = bus.memWE & w_sel_data;
  assign w_push     = w_wr_data & (~w_full | w_pop);
  assign w_drop     = w_wr_data & w_full & ~w_pop;
  assign w_busy     = (r_state != ST_IDLE);
  assign w_tc       = (r_baud == BAUD_TC);
  assign w_status   = pack_status(4'(w_count), r_ovf, w_empty, w_full, w_busy);

  assign txd        = r_txd;
  assign irq        = w_empty & ~w_busy;
  assign bus.rdData = r_rd;

  periph_word_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   (bus.inData),
    .o_dout  (w_dout),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf <= 1'b0;
      r_rd  <= 16'h0000;
    end else begin
      if (w_drop)                         r_ovf <= 1'b1;
      else if (bus.memWE && w_sel_stat)   r_ovf <= 1'b0;
      r_rd <= w_sel_stat ? w_status : (w_sel_data ? w_dout : 16'h0000);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_baud     <= '0;
      r_bit      <= '0;
      r_byte_sel <= 1'b0;
      r_hold     <= 16'h0000;
      r_txd      <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_baud     <= w_baud_nxt;
      r_bit      <= w_bit_nxt;
      r_byte_sel <= w_sel_nxt;
      r_hold     <= w_hold_nxt;
      r_txd      <= w_txd_nxt;
    end
  end

  // txd is registered from next-state values so the line never glitches.
  always_comb begin
    w_state_nxt = r_state;
    w_baud_nxt  = w_tc ? '0 : r_baud + 1'b1;
    w_bit_nxt   = r_bit;
    w_sel_nxt   = r_byte_sel;
    w_hold_nxt  = r_hold;
    w_pop       = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        w_baud_nxt = '0;
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_hold_nxt  = w_dout;
          w_sel_nxt   = 1'b0;
          w_state_nxt = ST_START;
        end
      end
      ST_START: begin
        if (w_tc) begin
          w_bit_nxt   = 3'd0;
          w_state_nxt = ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_tc) begin
          if (r_bit == 3'd7) w_state_nxt = ST_STOP;
          else               w_bit_nxt   = r_bit + 3'd1;
        end
      end
      ST_STOP: begin
        if (w_tc) begin
          if (!r_byte_sel) begin
            w_sel_nxt   = 1'b1;
            w_state_nxt = ST_START;
          end else if (!w_empty) begin
            w_pop       = 1'b1;
            w_hold_nxt  = w_dout;
            w_sel_nxt   = 1'b0;
            w_state_nxt = ST_START;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    w_byte_nxt = w_sel_nxt ? w_hold_nxt[15:8] : w_hold_nxt[7:0];
    unique case (w_state_nxt)
      ST_START: w_txd_nxt = 1'b0;
      ST_DATA:  w_txd_nxt = w_byte_nxt[w_bit_nxt];
      default:  w_txd_nxt = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_periph_tx_responder.sv
// Directed bench: reset, single-word framing, FIFO fill/overflow, push-on-pop, back-to-back words, mid-frame reset.
module tb_periph_tx_responder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic txd, irq;
  int   n_cmp = 0;
  int   n_err = 0;
  int   t = 0;

  periph_tx_responder_if bus ();

  periph_tx_responder #(
    .BASE_ADDR    (16'hFF00),
    .CLKS_PER_BIT (4),
    .DEPTH_LOG2   (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .txd (txd),
    .irq (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    t += n;
  endtask

  task automatic store(input logic [15:0] a, input logic [15:0] d);
    bus.dataAddr = a;
    bus.inData   = d;
    bus.memWE    = 1'b1;
    tick(1);
    bus.memWE    = 1'b0;
  endtask

  // 0x5A then 0xA5, each framed start/8 data LSB-first/stop, index = bit-time
  logic [0:19] frame_a55a = 20'b0_01011010_1_0_10100101_1;
  logic [15:0] fill_words [9] = '{16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666,
                                   16'h7777, 16'h8888, 16'h9999, 16'hDEAD};

  initial begin
    bus.dataAddr = 16'h0000;
    bus.inData   = 16'h0000;
    bus.memWE    = 1'b0;

    #12;
    chk("rst_txd", {15'h0, txd}, 16'h0001);
    chk("rst_irq", {15'h0, irq}, 16'h0001);
    chk("rst_rd",  bus.rdData,   16'h0000);
    @(negedge clk);
    rst = 1'b0;
    bus.dataAddr = 16'hFF01;
    tick(1);
    chk("idle_status", bus.rdData, 16'h0004);

    // Single word 0xA55A
    store(16'hFF00, 16'hA55A);
    t = 0;
    chk("w1_pre_start_txd", {15'h0, txd}, 16'h0001);
    tick(1);
    chk("w1_start_edge", {15'h0, txd}, 16'h0000);
    for (int b = 0; b < 20; b++) begin
      tick(4*b + 2 - t);
      chk($sformatf("w1_bit%0d", b), {15'h0, txd}, {15'h0, frame_a55a[b]});
      chk($sformatf("w1_irq%0d", b), {15'h0, irq}, 16'h0000);
    end
    tick(80 - t);
    chk("w1_last_stop_txd", {15'h0, txd}, 16'h0001);
    chk("w1_last_stop_irq", {15'h0, irq}, 16'h0000);
    tick(1);
    chk("w1_done_irq", {15'h0, irq}, 16'h0001);
    bus.dataAddr = 16'hFF01;
    tick(1);
    chk("w1_done_status", bus.rdData, 16'h0004);
    tick(3);

    // Word 1 busy, then nine back-to-back stores: eight fill, ninth overflows
    store(16'hFF00, 16'h1111);
    t = 0;
    tick(2);
    for (int k = 0; k < 9; k++) begin
      bus.dataAddr = 16'hFF00;
      bus.inData   = fill_words[k];
      bus.memWE    = 1'b1;
      tick(1);
    end
    bus.memWE = 1'b0;
    bus.dataAddr = 16'hFF01;
    tick(1);
    chk("full_ovf_status", bus.rdData, 16'h008B);
    store(16'hFF01, 16'h1234);
    tick(1);
    chk("ovf_cleared_status", bus.rdData, 16'h0083);
    bus.dataAddr = 16'hFF00;
    tick(1);
    chk("head_peek", bus.rdData, 16'h2222);

    // Last cycle of word 1's high stop bit: FSM pops from the full FIFO
    tick(80 - t);
    chk("w1_stop_before_pop", {15'h0, txd}, 16'h0001);
    store(16'hFF00, 16'hAAAA);
    chk("w2_start_no_gap", {15'h0, txd}, 16'h0000);
    bus.dataAddr = 16'hFF01;
    tick(1);
    chk("push_on_pop_status", bus.rdData, 16'h0083);
    bus.dataAddr = 16'hFF00;
    tick(1);
    chk("head_after_pop", bus.rdData, 16'h3333);

    // Word 2 = 0x2222: low byte 0x22, data bit1 = 1, data bit3 = 0
    tick(90 - t);
    chk("w2_data_bit1", {15'h0, txd}, 16'h0001);
    tick(98 - t);
    chk("w2_data_bit3", {15'h0, txd}, 16'h0000);
    rst = 1'b1;
    #1;
    chk("async_rst_txd", {15'h0, txd}, 16'h0001);
    chk("async_rst_irq", {15'h0, irq}, 16'h0001);
    @(negedge clk);
    rst = 1'b0;
    bus.dataAddr = 16'hFF01;
    @(negedge clk);
    chk("post_rst_status", bus.rdData, 16'h0004);
    for (int i = 0; i < 6; i++) begin
      repeat (10) @(negedge clk);
      chk($sformatf("post_rst_quiet%0d", i), {15'h0, txd}, 16'h0001);
    end
    chk("post_rst_status_end", bus.rdData, 16'h0004);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/periph_tx_responder.md
Name: periph_tx_responder

Overview:
Memory-mapped peripheral responder on the CPU data-memory port (dataAddr / inData / memWE, as driven by the Ex-to-Mem register).
- Captures CPU stores to its address window into a word FIFO.
- Serializes each word as two 8N1 UART bytes: low byte first, then high byte.
- Returns a status word on reads, so software can poll before storing.

Parameters:
BASE_ADDR, 16'hFF00, first address of the 2-word window (DATA at BASE, STATUS at BASE+1)
CLKS_PER_BIT, 434, clk cycles per UART bit; legal range ≥2
DEPTH_LOG2, 3, log2 of FIFO depth (depth = 8 words)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
dataAddr  input  16  CPU data address (Mem stage)
inData  input  16  CPU store data
memWE  input  1  CPU store strobe, one cycle per store
rdData  output  16  registered read data for dataAddr
txd  output  1  UART serial out, idle high
irq  output  1  high while FIFO empty and shifter idle

Behaviour:
- Reset (async, rst=1): FIFO pointers and count=0, overflow=0, shifter state=IDLE, bit/baud counters=0, txd=1, rdData=0, irq=1.
- Decode: sel_data = (dataAddr==BASE_ADDR); sel_stat = (dataAddr==BASE_ADDR+1). Any other address is ignored and gives rdData=0.
- Store to DATA (memWE & sel_data):
  - FIFO not full: push inData at the next clk edge.
  - FIFO full: drop the word and set sticky overflow.
- Store to STATUS (memWE & sel_stat): clears overflow; data value ignored.
- Read: rdData registered every cycle, so it is valid one cycle after dataAddr is presented.
  - STATUS: {8'b0, count[3:0] zero-extended to 4 bits, overflow, empty, full, busy} as bits [15:8]=0, [7:4]=count, [3]=overflow, [2]=empty, [1]=full, [0]=busy.
  - DATA: returns the FIFO head word (peek; no pop).
- FIFO: circular, pointers wrap modulo 2^DEPTH_LOG2. count ranges 0..depth.
  - full = (count==depth); empty = (count==0).
  - Simultaneous push and pop when full: the pop frees a slot, so the push is accepted. Count stays constant; no overflow is set.
  - Simultaneous push and pop when empty: cannot occur, since pop requires !empty.
- Shifter FSM: IDLE -> START -> DATA -> STOP -> (HIGH byte? START : IDLE/next word).
  - IDLE: if !empty, pop the head word into a 16-bit shift holder, set byte_sel=0, go to START. The pop happens on the same edge as the transition.
  - START: txd=0 for CLKS_PER_BIT cycles.
  - DATA: 8 bits, LSB first, each CLKS_PER_BIT cycles. The bit index counts 0..7.
  - STOP: txd=1 for CLKS_PER_BIT cycles. On exit:
    - byte_sel==0: set byte_sel=1 and go to START (high byte).
    - byte_sel==1 and FIFO non-empty: pop and go directly to START, so there is no idle bit between words.
    - otherwise: go to IDLE.
  - busy = (state != IDLE).
- Frame timing:
  - One word = 20 bit-times = 20*CLKS_PER_BIT cycles.
  - First START edge on txd appears 1 cycle after the push cycle, when starting from IDLE with the FIFO empty.
- Baud counter: counts 0..CLKS_PER_BIT-1 and advances the bit on the terminal count. It resets to 0 on every state entry.
- Reset mid-frame: txd returns to 1 immediately (asynchronously). The FIFO contents are discarded, and no partial byte is resumed.
- The CPU stall signal is not consumed. The strobe is assumed to be one cycle per accepted store (memWE already qualified upstream).

Decomposition:
- Shared package holds the state encoding constants (ST_IDLE=2'd0, ST_START=2'd1, ST_DATA=2'd2, ST_STOP=2'd3) and the STATUS bit-position constants.
- Natural sub-module: periph_word_fifo.
  - Parameterized DEPTH_LOG2; 16-bit width.
  - Ports: push/pop/din/dout/full/empty/count.
  - Async reset.
- The top holds the decode, the status register and the UART FSM.

Test Plan:
- Reset then idle, with CLKS_PER_BIT=4 → txd=1, irq=1, STATUS read = 16'h0004 (empty only).
- Store 16'hA55A to FF00 → txd sequence:
  - low byte: start 0, bits 0,1,0,1,1,0,1,0 (0x5A LSB first), stop 1, each bit 4 cycles;
  - high byte: start 0, bits 1,0,1,0,0,1,0,1 (0xA5 LSB first), stop 1;
  - then idle; 80 cycles total; busy=1 throughout.
- Nine back-to-back stores while the shifter is busy on word 1 → words 2–9 fill the FIFO (count=8, full=1), the ninth store sets overflow, and STATUS reads 16'h008B.
  - Store to FF01 → overflow=0.
- Store issued on the exact cycle the FSM pops from a full FIFO → accepted, count unchanged at 8, overflow stays 0.
- Two stored words → second word's start bit begins on the cycle immediately after the first word's high-byte stop bit, with no extra idle.
- Assert rst mid DATA bit 3 → txd=1 asynchronously, STATUS=16'h0004 one cycle after reset release, no further transmission.
